// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC local endpoint.
package noc_pkg;

    localparam int FLIT_W = 16;

    typedef struct packed {
        logic [7:0] payload;
        logic [7:0] dest;
    } flit_t;

    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_EJ_OVF     = 1;

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only together with a pop.
// rdata reads as zero while the FIFO is empty.
module noc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/noc_local_endpoint.sv
// Router L-port endpoint: credit-controlled flit injection and credit-returning ejection.
// Optional flit counters are built when NOC_EP_STATS_EN is defined.
module noc_local_endpoint
    import noc_pkg::*;
#(
    parameter int CREDITS   = 4,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inj_valid,
    output logic              inj_ready,
    input  logic [7:0]        inj_dest,
    input  logic [7:0]        inj_payload,
    output logic [FLIT_W-1:0] net_tx_data,
    output logic              net_tx_enable,
    input  logic              net_tx_credit,
    input  logic [FLIT_W-1:0] net_rx_data,
    input  logic              net_rx_enable,
    output logic              net_rx_credit,
    output logic              ej_valid,
    input  logic              ej_ready,
    output logic [FLIT_W-1:0] ej_data,
`ifdef NOC_EP_STATS_EN
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count,
`endif
    output logic [1:0]        err
);

    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]     ccnt_q, ccnt_d;
    logic [FLIT_W-1:0] tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              rx_credit_q, rx_credit_d;
    logic [1:0]        err_q, err_d;

    flit_t             inj_word;
    logic [FLIT_W-1:0] inj_head, send_word;
    logic              inj_full, inj_empty, inj_accept, inj_push, inj_pop, fire;
    logic              ej_full, ej_empty, ej_pop;

    // Handshake: a word moves when valid && ready are both high at a rising edge.
    assign inj_word.payload = inj_payload;
    assign inj_word.dest    = inj_dest;
    assign inj_ready  = !inj_full && !rst;
    assign inj_accept = inj_valid && inj_ready;

    // An arriving word bypasses an empty FIFO so it can leave in the same cycle.
    assign fire      = (!inj_empty || inj_accept) && (ccnt_q != '0);
    assign send_word = inj_empty ? inj_word : inj_head;
    assign inj_push  = inj_accept && !(inj_empty && fire);
    assign inj_pop   = fire && !inj_empty;

    assign ej_valid = !ej_empty;
    assign ej_pop   = ej_valid && ej_ready;

    noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inj_push),
        .wdata (inj_word),
        .pop   (inj_pop),
        .rdata (inj_head),
        .full  (inj_full),
        .empty (inj_empty)
    );

    noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (net_rx_enable),
        .wdata (net_rx_data),
        .pop   (ej_pop),
        .rdata (ej_data),
        .full  (ej_full),
        .empty (ej_empty)
    );

    always_comb begin
        ccnt_d      = ccnt_q;
        err_d       = err_q;
        tx_en_d     = fire;
        tx_data_d   = fire ? send_word : tx_data_q;
        rx_credit_d = ej_pop;
        if (fire && !net_tx_credit) begin
            ccnt_d = ccnt_q - 1'b1;
        end else if (!fire && net_tx_credit) begin
            if (ccnt_q == CW'(CREDITS)) err_d[ERR_CREDIT_OVF] = 1'b1;
            else                        ccnt_d = ccnt_q + 1'b1;
        end
        if (net_rx_enable && ej_full && !ej_pop) err_d[ERR_EJ_OVF] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccnt_q      <= CW'(CREDITS);
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            rx_credit_q <= 1'b0;
            err_q       <= '0;
        end else begin
            ccnt_q      <= ccnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            rx_credit_q <= rx_credit_d;
            err_q       <= err_d;
        end
    end

    assign net_tx_data   = tx_data_q;
    assign net_tx_enable = tx_en_q;
    assign net_rx_credit = rx_credit_q;
    assign err           = err_q;

`ifdef NOC_EP_STATS_EN
    logic [15:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;

    always_comb begin
        tx_count_d = tx_count_q + {15'd0, tx_en_q};
        rx_count_d = rx_count_q + {15'd0, net_rx_enable && (!ej_full || ej_pop)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Self-checking bench for noc_local_endpoint: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_noc_local_endpoint;

    localparam int CREDITS   = 4;
    localparam int INJ_DEPTH = 4;
    localparam int EJ_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inj_valid, inj_ready;
    logic [7:0]  inj_dest, inj_payload;
    logic [15:0] net_tx_data;
    logic        net_tx_enable, net_tx_credit;
    logic [15:0] net_rx_data;
    logic        net_rx_enable, net_rx_credit;
    logic        ej_valid, ej_ready;
    logic [15:0] ej_data;
    logic [1:0]  err;
`ifdef NOC_EP_STATS_EN
    logic [15:0] tx_count, rx_count;
`endif

    always #5 clk = ~clk;

    noc_local_endpoint #(.CREDITS(CREDITS), .INJ_DEPTH(INJ_DEPTH), .EJ_DEPTH(EJ_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .inj_valid     (inj_valid),
        .inj_ready     (inj_ready),
        .inj_dest      (inj_dest),
        .inj_payload   (inj_payload),
        .net_tx_data   (net_tx_data),
        .net_tx_enable (net_tx_enable),
        .net_tx_credit (net_tx_credit),
        .net_rx_data   (net_rx_data),
        .net_rx_enable (net_rx_enable),
        .net_rx_credit (net_rx_credit),
        .ej_valid      (ej_valid),
        .ej_ready      (ej_ready),
        .ej_data       (ej_data),
`ifdef NOC_EP_STATS_EN
        .tx_count      (tx_count),
        .rx_count      (rx_count),
`endif
        .err           (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tx_seen = 0;
    int rx_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: message queues and a credit integer, stepped once per rising edge.
    logic [15:0] m_inj_q[$];
    logic [15:0] m_ej_q[$];
    int          m_ccnt;
    logic        m_tx_en, m_rx_credit;
    logic [15:0] m_tx_data;
    logic [1:0]  m_err;
    bit          m_started = 0;

    always @(posedge clk) begin
        bit          acc, fire, ejv, pop;
        logic [15:0] w, sent;
        m_started = 1;
        if (rst) begin
            m_inj_q.delete();
            m_ej_q.delete();
            m_ccnt = CREDITS;
            m_tx_en = 0;
            m_tx_data = '0;
            m_rx_credit = 0;
            m_err = '0;
        end else begin
            acc  = inj_valid && (m_inj_q.size() < INJ_DEPTH);
            w    = {inj_payload, inj_dest};
            fire = (m_inj_q.size() > 0 || acc) && (m_ccnt > 0);
            sent = w;
            if (fire && m_inj_q.size() > 0) begin
                sent = m_inj_q.pop_front();
                if (acc) m_inj_q.push_back(w);
            end else if (!fire && acc) begin
                m_inj_q.push_back(w);
            end
            m_tx_en = fire;
            if (fire) m_tx_data = sent;
            if (fire && !net_tx_credit) m_ccnt--;
            else if (!fire && net_tx_credit) begin
                if (m_ccnt == CREDITS) m_err[0] = 1'b1;
                else m_ccnt++;
            end
            ejv = (m_ej_q.size() > 0);
            pop = ejv && ej_ready;
            if (pop) void'(m_ej_q.pop_front());
            if (net_rx_enable) begin
                if (m_ej_q.size() < EJ_DEPTH) m_ej_q.push_back(net_rx_data);
                else m_err[1] = 1'b1;
            end
            m_rx_credit = pop;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("inj_ready", 32'(inj_ready), 32'(!rst && m_inj_q.size() < INJ_DEPTH));
            check("net_tx_enable", 32'(net_tx_enable), 32'(m_tx_en));
            check("net_tx_data", 32'(net_tx_data), 32'(m_tx_data));
            check("net_rx_credit", 32'(net_rx_credit), 32'(m_rx_credit));
            check("ej_valid", 32'(ej_valid), 32'(m_ej_q.size() > 0));
            if (m_ej_q.size() > 0) check("ej_data", 32'(ej_data), 32'(m_ej_q[0]));
            check("err", 32'(err), 32'(m_err));
            if (net_tx_enable) tx_seen++;
            if (net_rx_credit) rx_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals [5];
        rst = 1; inj_valid = 0; inj_dest = '0; inj_payload = '0;
        net_tx_credit = 0; net_rx_data = '0; net_rx_enable = 0; ej_ready = 0;
        repeat (3) step();
        settle();
        check("rst_inj_ready", 32'(inj_ready), 32'd0);
        rst = 0;
        settle();
        check("post_rst_inj_ready", 32'(inj_ready), 32'd1);
        check("rst_tx_en", 32'(net_tx_enable), 32'd0);
        check("rst_tx_data", 32'(net_tx_data), 32'd0);
        check("rst_ej_data", 32'(ej_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single message
        inj_valid = 1; inj_payload = 8'hA5; inj_dest = 8'h12;
        step();
        inj_valid = 0;
        settle();
        check("first_tx_en", 32'(net_tx_enable), 32'd1);
        check("first_tx_data", 32'(net_tx_data), 32'hA512);
        net_tx_credit = 1; step(); net_tx_credit = 0;

        // Credit exhaustion and injection back-pressure
        tx_seen = 0;
        for (int i = 0; i < 6; i++) begin
            inj_valid = 1; inj_dest = 8'(i); inj_payload = 8'(8'h30 + i);
            step();
        end
        inj_valid = 0;
        repeat (4) step();
        check("six_inj_sent", 32'(tx_seen), 32'd4);
        for (int i = 6; i < 8; i++) begin
            inj_valid = 1; inj_dest = 8'(i); inj_payload = 8'(8'h30 + i);
            step();
        end
        inj_valid = 0;
        settle();
        check("inj_full_ready", 32'(inj_ready), 32'd0);
        net_tx_credit = 1; step(); net_tx_credit = 0;
        step(); settle();
        check("fifth_tx_en", 32'(net_tx_enable), 32'd1);
        check("fifth_tx_data", 32'(net_tx_data), 32'h3404);
        for (int i = 0; i < 7; i++) begin
            net_tx_credit = 1; step();
        end
        net_tx_credit = 0;
        repeat (3) step();

        // Send and credit return in the same cycle
        tx_seen = 0;
        for (int i = 0; i < 20; i++) begin
            inj_valid = 1; net_tx_credit = 1;
            inj_dest = 8'($urandom); inj_payload = 8'($urandom);
            step();
        end
        inj_valid = 0; net_tx_credit = 0;
        repeat (2) step();
        check("simul_sent", 32'(tx_seen), 32'd20);

        // Credit overflow at full count
        net_tx_credit = 1; step(); net_tx_credit = 0;
        settle();
        check("credit_ovf_err", 32'(err), 32'd1);

        // Ejection overflow and in-order drain
        rx_seen = 0;
        for (int i = 0; i < 5; i++) begin
            vals[i] = 16'($urandom);
            net_rx_enable = 1; net_rx_data = vals[i];
            step();
        end
        net_rx_enable = 0;
        settle();
        check("ej_ovf_err", 32'(err), 32'd3);
        check("ej_no_credit", 32'(rx_seen), 32'd0);
        ej_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("ej_order", 32'(ej_data), 32'(vals[i]));
            step(); settle();
        end
        ej_ready = 0;
        step(); settle();
        check("ej_credits", 32'(rx_seen), 32'd4);
        check("ej_drained", 32'(ej_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            inj_valid     = 1'($urandom_range(0, 1));
            inj_dest      = 8'($urandom);
            inj_payload   = 8'($urandom);
            net_tx_credit = ($urandom_range(0, 2) == 0);
            net_rx_enable = 1'($urandom_range(0, 1));
            net_rx_data   = 16'($urandom);
            ej_ready      = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            inj_valid = 1; net_rx_enable = 1; net_rx_data = 16'($urandom);
            inj_dest = 8'($urandom); inj_payload = 8'($urandom);
            step();
        end
        rst = 1;
        step(); settle();
        check("mid_rst_tx_en", 32'(net_tx_enable), 32'd0);
        check("mid_rst_tx_data", 32'(net_tx_data), 32'd0);
        check("mid_rst_rx_credit", 32'(net_rx_credit), 32'd0);
        check("mid_rst_ej_valid", 32'(ej_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_inj_ready", 32'(inj_ready), 32'd0);
        rst = 0; inj_valid = 0; net_rx_enable = 0; net_tx_credit = 0; ej_ready = 0;
        step();
        tx_seen = 0;
        for (int i = 0; i < 5; i++) begin
            inj_valid = 1; inj_dest = 8'($urandom); inj_payload = 8'($urandom);
            step();
        end
        inj_valid = 0;
        repeat (3) step();
        check("post_rst_credits", 32'(tx_seen), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
